// File: rtl/video_eth_pkg.sv
// ----------------------------------------------------------------------------
// video_eth_pkg
// Shared types and constants for the video line packer.
//   tx_state_e    : TX FSM states (idle, start pulse, payload, wait for done, gap)
//   HDR_MAGIC_DEF : default upper half of the per-line header word
//   line_bytes()  : payload bytes per line packet
//   line_words()  : 32-bit words per line packet
// Configuration macro: LINE_HDR_EN (prepends a {magic, line} header word).
// ----------------------------------------------------------------------------
package video_eth_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StSend,
        StWaitDone,
        StGap
    } tx_state_e;

    localparam logic [15:0] HDR_MAGIC_DEF = 16'h5AA5;

`ifdef LINE_HDR_EN
    localparam int unsigned HDR_WORDS = 1;
`else
    localparam int unsigned HDR_WORDS = 0;
`endif

    function automatic logic [15:0] line_bytes(input int unsigned h_pix);
        return 16'(h_pix * 2 + HDR_WORDS * 4);
    endfunction

    function automatic logic [15:0] line_words(input int unsigned h_pix);
        return 16'(h_pix / 2 + HDR_WORDS);
    endfunction

endpackage

// File: rtl/video_eth_line_packer_if.sv
// ----------------------------------------------------------------------------
// video_eth_line_packer_if
// Bundles the pixel input stream and the UDP tx handshake of the line packer.
//   pix_vsync/pix_de/pix_data        : pixel stream into the packer
//   tx_req/tx_done                   : UDP tx word request / packet done
//   tx_start_en/tx_byte_num/tx_data  : packet start, length and payload word
//   line_ovf/frame_cnt               : status
// slave  : the packer side; master : the source/sink environment.
// ----------------------------------------------------------------------------
interface video_eth_line_packer_if;
    logic        pix_vsync;
    logic        pix_de;
    logic [15:0] pix_data;
    logic        tx_req;
    logic        tx_done;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic [31:0] tx_data;
    logic        line_ovf;
    logic [15:0] frame_cnt;

    modport master (
        output pix_vsync, pix_de, pix_data, tx_req, tx_done,
        input  tx_start_en, tx_byte_num, tx_data, line_ovf, frame_cnt
    );

    modport slave (
        input  pix_vsync, pix_de, pix_data, tx_req, tx_done,
        output tx_start_en, tx_byte_num, tx_data, line_ovf, frame_cnt
    );
endinterface

// File: rtl/eth_pix_fifo.sv
// ----------------------------------------------------------------------------
// eth_pix_fifo
// Single-clock first-word-fall-through FIFO, 32-bit wide, 2**FIFO_AW deep.
//   clk, rst        : clock, asynchronous active-high reset
//   i_clear         : synchronous flush (all pointers to zero)
//   i_wr_en, i_din  : write port (ignored when full)
//   i_wr_mark       : commit point, remembers the post-write pointer of this cycle
//   i_wr_rollback   : discard uncommitted words (write pointer back to the mark)
//   i_rd_en, o_dout : read port; o_dout shows the head word while not empty
//   o_full, o_empty : status
// ----------------------------------------------------------------------------
module eth_pix_fifo #(
    parameter int unsigned FIFO_AW = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_wr_en,
    input  logic [31:0] i_din,
    input  logic        i_wr_mark,
    input  logic        i_wr_rollback,
    input  logic        i_rd_en,
    output logic [31:0] o_dout,
    output logic        o_full,
    output logic        o_empty
);
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);

    logic [31:0]      r_mem [DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic [FIFO_AW:0] r_mark_ptr;
    logic [FIFO_AW:0] w_wr_ptr_d;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign o_dout  = r_mem[r_rd_ptr[FIFO_AW-1:0]];

    assign w_wr = i_wr_en && !o_full && !i_wr_rollback;
    assign w_rd = i_rd_en && !o_empty;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr;
        if (i_wr_rollback) begin
            w_wr_ptr_d = r_mark_ptr;
        end else if (w_wr) begin
            w_wr_ptr_d = r_wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mark_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mark_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_d;
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (i_wr_mark) begin
                r_mark_ptr <= w_wr_ptr_d;
            end
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr && !i_clear) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_din;
        end
    end
endmodule

// File: rtl/video_eth_line_packer.sv
// ----------------------------------------------------------------------------
// video_eth_line_packer
// Packs RGB565 pixels into 32-bit words, buffers complete lines in a word FIFO
// and hands one UDP payload per line to the UDP/GMII transmitter.
//   clk     : gmii_tx_clk
//   rst     : asynchronous reset, active-high
//   io_bus  : video_eth_line_packer_if.slave (pixel stream in, tx handshake out,
//             line_ovf sticky overflow flag, frame_cnt frame counter)
// Parameters: H_PIX (even), V_PIX, FIFO_AW, HDR_MAGIC.
// Configuration macro: LINE_HDR_EN (via video_eth_pkg) adds a {HDR_MAGIC, line}
// header word in front of every line payload.
// ----------------------------------------------------------------------------
module video_eth_line_packer
    import video_eth_pkg::*;
#(
    parameter int unsigned H_PIX     = 640,
    parameter int unsigned V_PIX     = 480,
    parameter int unsigned FIFO_AW   = 9,
    parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
    input logic                     clk,
    input logic                     rst,
    video_eth_line_packer_if.slave  io_bus
);
    localparam logic [15:0]      BYTE_NUM = line_bytes(H_PIX);
    localparam logic [15:0]      WORD_NUM = line_words(H_PIX);
    localparam bit               HDR_EN   = (HDR_WORDS != 0);
    localparam logic [FIFO_AW:0] LRDY_ONE = (FIFO_AW + 1)'(1);

    tx_state_e        r_state;
    tx_state_e        w_state_d;

    logic             r_phase;
    logic [15:0]      r_pix_hi;
    logic [15:0]      r_pix_cnt;
    logic             r_drop;
    logic [15:0]      r_wr_line;
    logic [15:0]      r_rd_line;
    logic [15:0]      r_frame_cnt;
    logic [FIFO_AW:0] r_lines_rdy;
    logic             r_line_ovf;
    logic [15:0]      r_byte_num;
    logic [15:0]      r_words_left;
    logic             r_hdr_pend;
    logic [31:0]      r_tx_data;

    logic             w_pix;
    logic             w_wr_req;
    logic             w_line_end;
    logic             w_ovf;
    logic             w_line_ok;
    logic             w_partial;
    logic             w_can_clear;
    logic             w_garbage;
    logic             w_start;
    logic             w_load;
    logic             w_serve;
    logic             w_fifo_rd;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [31:0]      w_fifo_dout;
    logic [31:0]      w_hdr_word;

    // Pixels arriving together with vsync belong to no line and are ignored.
    assign w_pix       = io_bus.pix_de && !io_bus.pix_vsync;
    assign w_wr_req    = w_pix && r_phase && !r_drop;
    assign w_line_end  = w_pix && (r_pix_cnt == 16'(H_PIX - 1));
    assign w_ovf       = w_wr_req && w_fifo_full;
    assign w_line_ok   = w_line_end && !r_drop && !w_ovf;
    // A vsync cutting a line that still has words in the FIFO.
    assign w_partial   = io_bus.pix_vsync && (r_pix_cnt != 16'd0) && !r_drop;
    assign w_can_clear = (r_state == StIdle) && (r_lines_rdy == '0);
    assign w_garbage   = w_partial && !w_can_clear;

    assign w_start   = (r_state == StStart);
    assign w_load    = (r_state == StIdle) && (w_state_d == StStart);
    assign w_serve   = io_bus.tx_req && (r_words_left != 16'd0) &&
                       ((r_state == StSend) || (r_state == StWaitDone));
    assign w_fifo_rd = w_serve && !r_hdr_pend && !w_fifo_empty;
    assign w_hdr_word = {HDR_MAGIC, r_rd_line};

    eth_pix_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (w_partial && w_can_clear),
        .i_wr_en       (w_wr_req),
        .i_din         ({r_pix_hi, io_bus.pix_data}),
        .i_wr_mark     (w_line_ok || w_garbage),
        .i_wr_rollback (w_ovf),
        .i_rd_en       (w_fifo_rd),
        .o_dout        (w_fifo_dout),
        .o_full        (w_fifo_full),
        .o_empty       (w_fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:     if (r_lines_rdy != '0) w_state_d = StStart;
            StStart:    w_state_d = StSend;
            StSend:     if (w_serve && (r_words_left == 16'd1)) w_state_d = StWaitDone;
            StWaitDone: if (io_bus.tx_done) w_state_d = StGap;
            StGap:      w_state_d = StIdle;
            default:    w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase      <= 1'b0;
            r_pix_hi     <= '0;
            r_pix_cnt    <= '0;
            r_drop       <= 1'b0;
            r_wr_line    <= '0;
            r_rd_line    <= '0;
            r_frame_cnt  <= '0;
            r_lines_rdy  <= '0;
            r_line_ovf   <= 1'b0;
            r_byte_num   <= '0;
            r_words_left <= '0;
            r_hdr_pend   <= 1'b0;
            r_tx_data    <= '0;
        end else begin
            if (io_bus.pix_vsync) begin
                r_pix_cnt   <= '0;
                r_phase     <= 1'b0;
                r_drop      <= 1'b0;
                r_wr_line   <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else if (io_bus.pix_de) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_pix_hi <= io_bus.pix_data;
                end
                if (w_line_end) begin
                    r_pix_cnt <= '0;
                    r_drop    <= 1'b0;
                    if (w_line_ok) begin
                        r_wr_line <= (r_wr_line == 16'(V_PIX - 1)) ? 16'd0 : r_wr_line + 16'd1;
                    end
                end else begin
                    r_pix_cnt <= r_pix_cnt + 16'd1;
                    if (w_ovf) begin
                        r_drop <= 1'b1;
                    end
                end
            end

            if (w_ovf || w_garbage) begin
                r_line_ovf <= 1'b1;
            end

            unique case ({w_line_ok, w_start})
                2'b10:   r_lines_rdy <= r_lines_rdy + LRDY_ONE;
                2'b01:   r_lines_rdy <= r_lines_rdy - LRDY_ONE;
                default: r_lines_rdy <= r_lines_rdy;
            endcase

            if (w_load) begin
                r_byte_num   <= BYTE_NUM;
                r_words_left <= WORD_NUM;
                r_hdr_pend   <= HDR_EN;
            end else if (w_serve) begin
                r_words_left <= r_words_left - 16'd1;
                r_hdr_pend   <= 1'b0;
                r_tx_data    <= r_hdr_pend ? w_hdr_word : w_fifo_dout;
            end

            if (r_state == StGap) begin
                r_rd_line <= (r_rd_line == 16'(V_PIX - 1)) ? 16'd0 : r_rd_line + 16'd1;
            end
        end
    end

    assign io_bus.tx_start_en = w_start;
    assign io_bus.tx_byte_num = r_byte_num;
    assign io_bus.tx_data     = r_tx_data;
    assign io_bus.line_ovf    = r_line_ovf;
    assign io_bus.frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_video_eth_line_packer.sv
// ----------------------------------------------------------------------------
// tb_video_eth_line_packer
// Scoreboard bench: stimulus pushes expected packet lengths and payload words,
// a monitor pops and compares whenever the packer starts a packet or answers
// a tx_req. A responder process plays the UDP transmitter.
// Honours LINE_HDR_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_video_eth_line_packer;
    localparam int H_PIX   = 8;
    localparam int V_PIX   = 2;
    localparam int FIFO_AW = 3;
`ifdef LINE_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int WORDS = H_PIX / 2 + HDR;
    localparam int BYTES = H_PIX * 2 + 4 * HDR;

    logic clk = 1'b0;
    logic rst = 1'b1;

    video_eth_line_packer_if bus ();

    video_eth_line_packer #(
        .H_PIX     (H_PIX),
        .V_PIX     (V_PIX),
        .FIFO_AW   (FIFO_AW),
        .HDR_MAGIC (16'h5AA5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          failures  = 0;
    logic [31:0] exp_words [$];
    logic [15:0] exp_bn    [$];
    int          pending    = 0;
    bit          tx_en      = 1'b1;
    int          done_delay = 2;
    int          extra_req  = 0;
    int          req_limit  = -1;
    int          exp_line   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: tx_req seen at a rising edge yields tx_data one edge later.
    initial begin
        logic req_s;
        forever begin
            @(posedge clk);
            req_s = bus.tx_req && !rst;
            @(negedge clk);
            if (!rst) begin
                if (req_s) begin
                    if (exp_words.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tx_data: got unexpected word %h expected none", bus.tx_data);
                    end else begin
                        check("tx_data", bus.tx_data, exp_words.pop_front());
                    end
                end
                if (bus.tx_start_en) begin
                    pending++;
                    if (exp_bn.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tx_start_en: got unexpected packet start expected none");
                    end else begin
                        check("tx_byte_num", 32'(bus.tx_byte_num), 32'(exp_bn.pop_front()));
                    end
                end
            end
        end
    end

    // UDP tx model: one packet at a time, tx_req per word, tx_done after a delay.
    initial begin
        int nw;
        bus.tx_req  = 1'b0;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_en && pending > 0 && !rst) begin
                @(negedge clk);
                nw = (req_limit >= 0) ? req_limit : WORDS + extra_req;
                for (int i = 0; i < nw; i++) begin
                    bus.tx_req = 1'b1;
                    @(negedge clk);
                end
                bus.tx_req = 1'b0;
                if (req_limit < 0) begin
                    repeat (done_delay) @(negedge clk);
                    bus.tx_done = 1'b1;
                    @(negedge clk);
                    bus.tx_done = 1'b0;
                end
                pending--;
            end
        end
    end

    task automatic drive_pixels(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.pix_de   = 1'b1;
            bus.pix_data = 16'(base + i + 1);
        end
        @(negedge clk);
        bus.pix_de = 1'b0;
    endtask

    task automatic push_line(input int base);
        exp_bn.push_back(16'(BYTES));
        if (HDR != 0) exp_words.push_back({16'h5AA5, 16'(exp_line)});
        for (int k = 0; k < H_PIX / 2; k++) begin
            exp_words.push_back({16'(base + 2 * k + 1), 16'(base + 2 * k + 2)});
        end
        exp_line = (exp_line + 1) % V_PIX;
    endtask

    task automatic pulse_vsync();
        @(negedge clk);
        bus.pix_vsync = 1'b1;
        @(negedge clk);
        bus.pix_vsync = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_words.size() != 0 || pending != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL %s drain: got %0d words left expected 0", name, exp_words.size());
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        bus.pix_vsync = 1'b0;
        bus.pix_de    = 1'b0;
        bus.pix_data  = '0;
        repeat (3) @(negedge clk);

        check("reset tx_start_en", 32'(bus.tx_start_en), 32'd0);
        check("reset tx_byte_num", 32'(bus.tx_byte_num), 32'd0);
        check("reset tx_data",     bus.tx_data,          32'd0);
        check("reset line_ovf",    32'(bus.line_ovf),    32'd0);
        check("reset frame_cnt",   32'(bus.frame_cnt),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // One line 0001..0008, plus one surplus tx_req that repeats the last word.
        pulse_vsync();
        extra_req = 1;
        push_line(0);
        exp_words.push_back(32'h0007_0008);
        drive_pixels(0, H_PIX);
        wait_drain("single line");
        extra_req = 0;
        check("frame_cnt after vsync", 32'(bus.frame_cnt), 32'd1);

        // Two lines back-to-back while the first packet waits 50 cycles for tx_done.
        done_delay = 50;
        push_line(16'h10);
        push_line(16'h20);
        drive_pixels(16'h10, H_PIX);
        drive_pixels(16'h20, H_PIX);
        wait_drain("two lines");
        done_delay = 2;
        check("line_ovf after two lines", 32'(bus.line_ovf), 32'd0);

        // vsync mid-line while idle: partial words flushed, pixel count restarts.
        drive_pixels(16'h30, 3);
        pulse_vsync();
        push_line(16'h40);
        drive_pixels(16'h40, H_PIX);
        wait_drain("vsync mid-line");
        check("frame_cnt mid-line vsync", 32'(bus.frame_cnt), 32'd2);
        check("line_ovf after idle flush", 32'(bus.line_ovf), 32'd0);

        // Three lines into an 8-word FIFO with the transmitter stalled.
        tx_en = 1'b0;
        push_line(16'h50);
        push_line(16'h60);
        drive_pixels(16'h50, H_PIX);
        drive_pixels(16'h60, H_PIX);
        drive_pixels(16'h70, H_PIX);
        repeat (5) @(negedge clk);
        check("line_ovf on overflow", 32'(bus.line_ovf), 32'd1);
        tx_en = 1'b1;
        wait_drain("overflow");

        // Reset in the middle of a packet after two served words.
        req_limit = 2;
        exp_bn.push_back(16'(BYTES));
        if (HDR != 0) begin
            exp_words.push_back({16'h5AA5, 16'(exp_line)});
            exp_words.push_back(32'h0081_0082);
        end else begin
            exp_words.push_back(32'h0081_0082);
            exp_words.push_back(32'h0083_0084);
        end
        drive_pixels(16'h80, H_PIX);
        wait_drain("partial packet");
        rst = 1'b1;
        #1;
        check("rst tx_start_en", 32'(bus.tx_start_en), 32'd0);
        check("rst tx_byte_num", 32'(bus.tx_byte_num), 32'd0);
        check("rst tx_data",     bus.tx_data,          32'd0);
        check("rst line_ovf",    32'(bus.line_ovf),    32'd0);
        check("rst frame_cnt",   32'(bus.frame_cnt),   32'd0);
        check("rst fifo empty",  32'(dut.u_fifo.o_empty), 32'd1);
        @(negedge clk);
        pending   = 0;
        req_limit = -1;
        exp_line  = 0;
        rst       = 1'b0;
        @(negedge clk);
        push_line(16'h90);
        drive_pixels(16'h90, H_PIX);
        wait_drain("after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
